// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display path: standard timing sets,
// test-pattern select codes and the coordinate-width helper.
package vga_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33
  };

  localparam vga_timing_t SVGA_800x600 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
  };

  typedef enum logic [1:0] {
    PAT_EXT   = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_WHITE = 2'd3
  } pat_e;

  // Coordinate width wide enough for the larger of the two raster totals.
  function automatic int calc_cw(input int unsigned h_total, input int unsigned v_total);
    return $clog2((h_total > v_total) ? h_total : v_total);
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational colour source: external pixel, colour bars, grid or flat white.
// Output packing matches pixel_rgb: {b, g, r}, each CBITS wide.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CBITS    = 4,
  parameter int unsigned CW       = 10
) (
  input  logic [CW-1:0]        xpos,
  input  logic [CW-1:0]        ypos,
  input  logic [1:0]           pat_r,
  input  logic [3*CBITS-1:0]   pixel_rgb,
  output logic [3*CBITS-1:0]   rgb
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0] bar;
  logic       grid_on;

  // Bar index: highest bar whose left edge has been reached; bar 7 keeps the remainder.
  always_comb begin
    bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (32'(xpos) >= k * BAR_W) bar = 3'(k);
    end
  end

  assign grid_on = (xpos[3:0] == 4'd0) || (ypos[3:0] == 4'd0) ||
                   (32'(xpos) == H_ACTIVE - 1) || (32'(ypos) == V_ACTIVE - 1);

  // Select the colour for the current position according to the latched pattern.
  always_comb begin
    rgb = pixel_rgb;
    case (pat_e'(pat_r))
      PAT_EXT:   rgb = pixel_rgb;
      PAT_BARS:  rgb = {{CBITS{bar[2]}}, {CBITS{bar[1]}}, {CBITS{bar[0]}}};
      PAT_GRID:  rgb = {(3*CBITS){grid_on}};
      PAT_WHITE: rgb = '1;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with registered VGA output stage.
// Counters advance on ptick; outputs lag xpos/ypos by one pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640x480.h_active,
  parameter int unsigned H_FP     = VGA_640x480.h_fp,
  parameter int unsigned H_SYNC   = VGA_640x480.h_sync,
  parameter int unsigned H_BP     = VGA_640x480.h_bp,
  parameter int unsigned V_ACTIVE = VGA_640x480.v_active,
  parameter int unsigned V_FP     = VGA_640x480.v_fp,
  parameter int unsigned V_SYNC   = VGA_640x480.v_sync,
  parameter int unsigned V_BP     = VGA_640x480.v_bp,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CBITS    = 4,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int          CW      = calc_cw(H_TOTAL, V_TOTAL)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           pattern_sel,
  input  logic [3*CBITS-1:0]   pixel_rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic [CBITS-1:0]     red,
  output logic [CBITS-1:0]     green,
  output logic [CBITS-1:0]     blue,
  output logic                 active,
  output logic                 ptick,
  output logic [CW-1:0]        xpos,
  output logic [CW-1:0]        ypos,
  output logic                 ftick,
  output logic                 line_tick
);

  localparam int unsigned    DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]  V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]  X_LAST_VIS = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0]  Y_LAST_VIS = CW'(V_ACTIVE - 1);
  localparam int unsigned    HS_START   = H_ACTIVE + H_FP;
  localparam int unsigned    HS_END     = HS_START + H_SYNC;
  localparam int unsigned    VS_START   = V_ACTIVE + V_FP;
  localparam int unsigned    VS_END     = VS_START + V_SYNC;

  logic [DW-1:0]        div;
  logic [CW-1:0]        hcount;
  logic [CW-1:0]        vcount;
  pat_e                 pat_r;
  logic [3*CBITS-1:0]   pat_rgb;
  logic                 h_wrap;
  logic                 frame_wrap;
  logic                 in_hs;
  logic                 in_vs;
  logic                 in_active;

  // Gated by reset so a divide ratio of 1 still gives no pixel enable in reset.
  assign ptick      = enable && !reset && (div == DIV_LAST);
  assign h_wrap     = (hcount == H_LAST);
  assign frame_wrap = h_wrap && (vcount == V_LAST);
  assign in_hs      = (32'(hcount) >= HS_START) && (32'(hcount) < HS_END);
  assign in_vs      = (32'(vcount) >= VS_START) && (32'(vcount) < VS_END);
  assign in_active  = (32'(hcount) < H_ACTIVE) && (32'(vcount) < V_ACTIVE);
  assign xpos       = hcount;
  assign ypos       = vcount;

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CBITS    (CBITS),
    .CW       (CW)
  ) u_pattern (
    .xpos      (hcount),
    .ypos      (vcount),
    .pat_r     (pat_r),
    .pixel_rgb (pixel_rgb),
    .rgb       (pat_rgb)
  );

  // Pixel divider, raster counters and frame-aligned pattern latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div    <= '0;
      hcount <= '0;
      vcount <= '0;
      pat_r  <= PAT_EXT;
    end else if (!enable) begin
      div    <= '0;
      hcount <= '0;
      vcount <= '0;
      pat_r  <= pat_e'(pattern_sel);
    end else begin
      div <= (div == DIV_LAST) ? '0 : div + DW'(1);
      if (ptick) begin
        if (frame_wrap) pat_r <= pat_e'(pattern_sel);
        if (h_wrap) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + CW'(1);
        end else begin
          hcount <= hcount + CW'(1);
        end
      end
    end
  end

  // Output stage: captures syncs and colour for the position being left on each ptick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync  <= ~HS_POL;
      vsync  <= ~VS_POL;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      active <= 1'b0;
    end else if (!enable) begin
      hsync  <= ~HS_POL;
      vsync  <= ~VS_POL;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      active <= 1'b0;
    end else if (ptick) begin
      hsync               <= in_hs ? HS_POL : ~HS_POL;
      vsync               <= in_vs ? VS_POL : ~VS_POL;
      active              <= in_active;
      {blue, green, red}  <= in_active ? pat_rgb : '0;
    end
  end

  // Frame and line strobes, one clk after the last visible pixel's ptick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ftick     <= 1'b0;
      line_tick <= 1'b0;
    end else begin
      ftick     <= ptick && (hcount == X_LAST_VIS) && (vcount == Y_LAST_VIS);
      line_tick <= ptick && (hcount == X_LAST_VIS) && (32'(vcount) < V_ACTIVE);
    end
  end

endmodule
